mac_multilane: RTL and testbench

Parametrised multi-lane signed multiply-accumulate unit, the next generation of the team's 16-bit single-lane MAC. Each accepted beat multiplies LANES pairs of signed operands in a pipelined multiplier, sums the lane products, and adds the sum into a wide accumulator. A `finalize` request drains the pipeline, then emits the result once, rounded to the output width by saturation or truncation. It sits between the PE operand feeders and the result writeback path.

---
 rtl/mac_multilane.sv | 174 +++++++++++++++++
 tb/tb_mac_multilane.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_multilane.sv
// Multi-lane signed multiply-accumulate: pipelined lane multipliers, registered lane-sum,
// wide accumulator, and a finalize/drain sequence that emits one saturated or truncated result.
module mac_multilane #(
    parameter int DATA_W     = 16,
    parameter int LANES      = 4,
    parameter int MUL_STAGES = 2,
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 32,
    parameter int SATURATE   = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                finalize,
    input  logic [LANES*DATA_W-1:0]             a,
    input  logic [LANES*DATA_W-1:0]             b,
    output logic                                in_ready,
    output logic [OUT_W-1:0]                    out,
    output logic                                out_valid,
    output logic [2*DATA_W+$clog2(LANES)-1:0]   product_out,
    output logic                                overflow
);

    localparam int P_W   = 2 * DATA_W;
    localparam int PS_W  = P_W + $clog2(LANES);
    localparam int CNT_W = $clog2(MUL_STAGES + 2);

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic signed [P_W-1:0]   prod_q [MUL_STAGES][LANES];
    logic signed [P_W-1:0]   prod_d [MUL_STAGES][LANES];
    logic [MUL_STAGES-1:0]   pv_q, pv_d;

    logic signed [PS_W-1:0]  sum_q, sum_d;
    logic                    sv_q, sv_d;
    logic signed [PS_W-1:0]  lane_sum;

    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [ACC_W-1:0]        acc_ext;
    logic [ACC_W-1:0]        acc_sum;
    logic                    wrap;

    logic [OUT_W-1:0]        out_q, out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overflow_q, overflow_d;

    logic                    accept;
    logic                    done;
    logic                    fits;
    logic [ACC_W-OUT_W:0]    acc_top;
    logic [OUT_W-1:0]        conv;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (finalize)     state_d = DRAIN;
            DRAIN: if (cnt_q == '0)  state_d = ACCUM;
            default:                 state_d = ACCUM;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_q == ACCUM);
    end

    assign accept = in_ready & en;
    assign done   = (state_q == DRAIN) && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ACCUM && finalize) begin
            cnt_d = CNT_W'(MUL_STAGES + 1);
        end else if (state_q == DRAIN && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            prod_d[0][i] = P_W'($signed(a[i*DATA_W +: DATA_W])) *
                           P_W'($signed(b[i*DATA_W +: DATA_W]));
        end
        pv_d    = '0;
        pv_d[0] = accept;
        for (int unsigned s = 1; s < MUL_STAGES; s++) begin
            prod_d[s] = prod_q[s-1];
            pv_d[s]   = pv_q[s-1];
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + PS_W'(prod_q[MUL_STAGES-1][i]);
        end
        sv_d  = pv_q[MUL_STAGES-1];
        sum_d = pv_q[MUL_STAGES-1] ? lane_sum : sum_q;
    end

    // Signed overflow: operands agree in sign but the result does not.
    always_comb begin
        acc_ext = ACC_W'(sum_q);
        acc_sum = acc_q + acc_ext;
        wrap    = sv_q && (acc_q[ACC_W-1] == acc_ext[ACC_W-1]) &&
                  (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    end

    always_comb begin
        acc_top = acc_q[ACC_W-1:OUT_W-1];
        fits    = (&acc_top) | ~(|acc_top);
        if (SATURATE != 0 && !fits) begin
            conv = {acc_q[ACC_W-1], {(OUT_W-1){~acc_q[ACC_W-1]}}};
        end else begin
            conv = acc_q[OUT_W-1:0];
        end
    end

    // The sticky flag survives only through the result pulse; ongoing wraps still set it.
    always_comb begin
        acc_d       = sv_q ? acc_sum : acc_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        overflow_d  = (out_valid_q ? 1'b0 : overflow_q) | wrap;
        if (done) begin
            acc_d       = '0;
            out_d       = conv;
            out_valid_d = 1'b1;
            overflow_d  = overflow_d | ~fits;
        end
    end

    always_ff @(posedge clk) begin
        prod_q <= prod_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            pv_q        <= '0;
            sv_q        <= 1'b0;
            sum_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pv_q        <= pv_d;
            sv_q        <= sv_d;
            sum_q       <= sum_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign product_out = sum_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_mac_multilane.sv
// Directed self-checking bench for mac_multilane: a saturating and a truncating instance
// share the same stimulus; expected values are hand-computed constants.
module tb_mac_multilane;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int MS     = 2;
    localparam int ACC_W  = 40;
    localparam int OUT_W  = 32;
    localparam int PS_W   = 2*DATA_W + $clog2(LANES);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic                     finalize;
    logic [LANES*DATA_W-1:0]  a;
    logic [LANES*DATA_W-1:0]  b;

    logic                     s_in_ready, t_in_ready;
    logic [OUT_W-1:0]         s_out, t_out;
    logic                     s_out_valid, t_out_valid;
    logic [PS_W-1:0]          s_product_out, t_product_out;
    logic                     s_overflow, t_overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n, k, seen, p1, p2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_multilane #(
        .DATA_W(DATA_W), .LANES(LANES), .MUL_STAGES(MS),
        .ACC_W(ACC_W), .OUT_W(OUT_W), .SATURATE(1)
    ) u_sat (
        .clk(clk), .rst(rst), .en(en), .finalize(finalize), .a(a), .b(b),
        .in_ready(s_in_ready), .out(s_out), .out_valid(s_out_valid),
        .product_out(s_product_out), .overflow(s_overflow)
    );

    mac_multilane #(
        .DATA_W(DATA_W), .LANES(LANES), .MUL_STAGES(MS),
        .ACC_W(ACC_W), .OUT_W(OUT_W), .SATURATE(0)
    ) u_trunc (
        .clk(clk), .rst(rst), .en(en), .finalize(finalize), .a(a), .b(b),
        .in_ready(t_in_ready), .out(t_out), .out_valid(t_out_valid),
        .product_out(t_product_out), .overflow(t_overflow)
    );

    function automatic logic [LANES*DATA_W-1:0] pack4(input int l0, input int l1,
                                                       input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input int budget, output int cnt);
        cnt = 0;
        while (cnt < budget && s_out_valid !== 1'b1) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; finalize = 1'b0; a = '0; b = '0;
        step(); step();
        rst = 1'b0;

        chk("rst_out", $signed(s_out), 0);
        chk("rst_out_valid", s_out_valid, 0);
        chk("rst_product_out", $signed(s_product_out), 0);
        chk("rst_overflow", s_overflow, 0);
        chk("rst_in_ready", s_in_ready, 1);

        // basic accumulation
        en = 1'b1; a = pack4(10, 6, 3, 0); b = pack4(5, 7, 4, 0);
        step();
        a = pack4(1, 1, 1, 1); b = pack4(-2, -2, -2, -2);
        step();
        en = 1'b0; a = '0; b = '0;
        step();
        chk("basic_psum0", $signed(s_product_out), 104);
        step();
        chk("basic_psum1", $signed(s_product_out), -8);
        finalize = 1'b1;
        step();
        finalize = 1'b0;
        chk("basic_in_ready_drain", s_in_ready, 0);
        wait_pulse(20, n);
        chk("basic_latency", n, MS + 2);
        chk("basic_out", $signed(s_out), 96);
        chk("basic_overflow", s_overflow, 0);
        step();
        chk("basic_pulse_width", s_out_valid, 0);
        chk("basic_out_held", $signed(s_out), 96);

        // finalize together with a beat; the next beat (in_ready=0) is dropped
        en = 1'b1; finalize = 1'b1; a = pack4(3, 3, 3, 3); b = pack4(3, 3, 3, 3);
        step();
        finalize = 1'b0;
        chk("same_in_ready_drain", s_in_ready, 0);
        step();
        en = 1'b0; a = '0; b = '0;
        wait_pulse(20, n);
        chk("same_latency", n + 1, MS + 2);
        chk("same_out", $signed(s_out), 36);
        step();
        finalize = 1'b1;
        step();
        finalize = 1'b0;
        wait_pulse(20, n);
        chk("empty_latency", n, MS + 2);
        chk("empty_out", $signed(s_out), 0);
        step();

        // saturation / truncation, positive
        en = 1'b1; finalize = 1'b1;
        a = pack4(32767, 32767, 32767, 32767); b = pack4(32767, 32767, 32767, 32767);
        step();
        en = 1'b0; finalize = 1'b0; a = '0; b = '0;
        wait_pulse(20, n);
        chk("sat_pos_out", $signed(s_out), 64'sd2147483647);
        chk("sat_pos_overflow", s_overflow, 1);
        chk("trunc_pos_valid", t_out_valid, 1);
        chk("trunc_pos_out", $signed(t_out), -262140);
        chk("trunc_pos_overflow", t_overflow, 1);
        step();
        chk("sat_overflow_clear", s_overflow, 0);
        chk("trunc_overflow_clear", t_overflow, 0);

        // saturation / truncation, negative
        en = 1'b1; finalize = 1'b1;
        a = pack4(32767, 32767, 32767, 32767); b = pack4(-32768, -32768, -32768, -32768);
        step();
        en = 1'b0; finalize = 1'b0; a = '0; b = '0;
        wait_pulse(20, n);
        chk("sat_neg_out", $signed(s_out), -64'sd2147483648);
        chk("sat_neg_overflow", s_overflow, 1);
        chk("trunc_neg_out", $signed(t_out), 131072);
        step();

        // reset one cycle into the drain
        en = 1'b1; a = pack4(10, 0, 0, 0); b = pack4(5, 0, 0, 0);
        step();
        en = 1'b0; a = '0; b = '0; finalize = 1'b1;
        step();
        finalize = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rd_out", $signed(s_out), 0);
        chk("rd_out_valid", s_out_valid, 0);
        chk("rd_product_out", $signed(s_product_out), 0);
        chk("rd_overflow", s_overflow, 0);
        chk("rd_in_ready", s_in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_out_valid === 1'b1) seen++;
        end
        chk("rd_no_pulse", seen, 0);
        en = 1'b1; finalize = 1'b1; a = pack4(2, 0, 0, 0); b = pack4(7, 0, 0, 0);
        step();
        en = 1'b0; finalize = 1'b0; a = '0; b = '0;
        wait_pulse(20, n);
        chk("rd_new_out", $signed(s_out), 14);
        step();

        // back-to-back finalize
        en = 1'b1; finalize = 1'b1; a = pack4(1, 0, 0, 0); b = pack4(5, 0, 0, 0);
        step();
        en = 1'b0; finalize = 1'b0; a = '0; b = '0;
        wait_pulse(20, n);
        p1 = cyc;
        chk("b2b_first_out", $signed(s_out), 5);
        k = 0;
        while (s_in_ready !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        finalize = 1'b1;
        step();
        finalize = 1'b0;
        wait_pulse(20, n);
        p2 = cyc;
        chk("b2b_spacing", p2 - p1, MS + 3);
        chk("b2b_second_out", $signed(s_out), 0);
        chk("b2b_second_valid", s_out_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
